parity_stream_chk: RTL and testbench
====================================

// Module: parity_stream_chk
// PURPOSE
//  Parametrised, pipelined parity generator/checker for a valid/ready word stream.
//  - Generate mode: computes the even or odd parity bit of each DATA_W-bit word.
//  - Check mode: validates each {data, parity} pair.
//  - Successor to the fixed 4-bit combinational even-parity checker. Adds width, odd/even
//    select, flow control, a sticky error flag and an optional error counter.
//  - Sits between a word producer and a consumer on the datapath.
// PARAMETERS
//  DATA_W  8  data word width in bits (>=1)
//  CNT_W   8  error counter width (only used when PARITY_ERR_CNT_EN is defined)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  odd_sel     in   1       0 = even parity, 1 = odd parity; sampled on acceptance
//  chk_mode    in   1       0 = generate, 1 = check; sampled on acceptance
//  in_valid    in   1       input word valid
//  in_ready    out  1       block can accept a word
//  in_data     in   DATA_W  input word
//  in_par      in   1       received parity bit (check mode only)
//  out_valid   out  1       output word valid
//  out_ready   in   1       consumer accepts the output
//  out_data    out  DATA_W  registered copy of in_data
//  out_par     out  1       generate: computed parity; check: in_par passed through
//  out_err     out  1       check mode: parity mismatch on this word (0 in generate mode)
//  err_clr     in   1       synchronous clear of err_sticky and err_cnt
//  err_sticky  out  1       set by any accepted erroneous word
//  err_cnt     out  CNT_W   saturating error count (PARITY_ERR_CNT_EN only)
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid, out_data, out_par, out_err, err_sticky, err_cnt = 0.
//    in_ready = 1 once rst_n deasserts.
//  - Reset mid-transfer discards the held word. No output is produced for it.
//  - Handshake:
//    - in_ready = !out_valid || out_ready (combinational; one-entry pipeline register).
//    - Accept when in_valid && in_ready. Results are registered one cycle later (latency 1).
//    - Full throughput: 1 word/cycle while out_ready = 1.
//    - While out_valid && !out_ready: out_* hold stable and in_ready = 0.
//    - out_valid clears when out_ready = 1 and no new word is accepted.
//  - Arithmetic, with p = ^in_data:
//    - Generate: out_par = p ^ odd_sel.
//    - Check: out_err = (p ^ in_par) != odd_sel.
//  - odd_sel and chk_mode are per-word. A change between words takes effect on the next
//    accepted word only.
//  - err_sticky:
//    - Set on the acceptance cycle +1 of any word with an error.
//    - err_clr clears it.
//    - Simultaneous set and clear: set wins.
// CONFIGURATION
//  PARITY_ERR_CNT_EN defined:
//    - err_cnt increments per erroneous accepted word, saturating at 2^CNT_W-1.
//    - err_clr zeroes it.
//    - Clear together with an error gives 1.
//  PARITY_ERR_CNT_EN undefined:
//    - err_cnt port and counter logic are absent.
//    - Everything else is identical.
// STRUCTURE
//  - Package parity_pkg:
//    - typedef enum {PAR_EVEN, PAR_ODD}
//    - typedef enum {MODE_GEN, MODE_CHK}
//    - default width localparams
//  - Sub-module parity_tree #(DATA_W):
//    - Combinational XOR-reduction tree, data -> p.
//    - Instantiated once.
//  - Top holds the handshake register, the error flag and the counter.
// TESTING
//  1. Reset:
//     - Assert rst_n=0 mid-stream -> all outputs 0 immediately, in_ready=1 after release.
//     - The held word is never emitted.
//  2. Generate, DATA_W=8:
//     - even 8'hA5 -> out_par=0; 8'h07 -> out_par=1; odd 8'h07 -> out_par=0.
//     - Each result appears exactly 1 cycle after acceptance.
//  3. Check, even:
//     - in_data=8'h0F, in_par=1 -> out_err=1, err_sticky=1, err_cnt=1.
//     - Same word with in_par=0 -> out_err=0.
//  4. Backpressure:
//     - out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_* stable, no word lost.
//     - Release -> words emerge in order, 1/cycle.
//  5. Saturation, CNT_W=2:
//     - 5 error words -> err_cnt=3.
//     - err_clr in the same cycle as an error -> err_cnt=1, err_sticky=1.
//  6. Exhaustive, DATA_W=4:
//     - All 32 {data, par} combinations, each with odd_sel=0 and odd_sel=1.
//     - out_err must match the reference model. Covers the legacy 4-bit checker case.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and default widths for the parity stream generator/checker.
package parity_pkg;

  localparam int unsigned PAR_DATA_W_DEF = 8;
  localparam int unsigned PAR_CNT_W_DEF  = 8;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_sel_e;

  typedef enum logic {
    MODE_GEN = 1'b0,
    MODE_CHK = 1'b1
  } mode_e;

endpackage

// File: rtl/parity_tree.sv
// Combinational XOR-reduction tree: par_o is the even parity (XOR) of data_i.
module parity_tree #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              par_o
);

  localparam int unsigned N_LEAF = 1 << $clog2(DATA_W);

  // Heap-ordered binary tree: node 0 is the root, leaves start at N_LEAF-1.
  logic [2*N_LEAF-2:0] node;

  for (genvar i = 0; i < N_LEAF; i++) begin : g_leaf
    if (i < DATA_W) begin : g_bit
      assign node[N_LEAF-1+i] = data_i[i];
    end else begin : g_pad
      assign node[N_LEAF-1+i] = 1'b0;
    end
  end

  for (genvar i = 0; i < N_LEAF - 1; i++) begin : g_node
    assign node[i] = node[2*i+1] ^ node[2*i+2];
  end

  assign par_o = node[0];

endmodule

// File: rtl/parity_stream_chk.sv
// Pipelined parity generator/checker on a valid/ready word stream (latency 1).
// Optional saturating error counter enabled by defining PARITY_ERR_CNT_EN.
module parity_stream_chk
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = PAR_DATA_W_DEF,
  parameter int unsigned CNT_W  = PAR_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              odd_sel,
  input  logic              chk_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par,
  output logic              out_err,
  input  logic              err_clr,
  output logic              err_sticky
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  err_cnt
`endif
);

  if (DATA_W < 1 || CNT_W < 1) begin : g_param_chk
    $error("parity_stream_chk: DATA_W and CNT_W must be >= 1");
  end

  logic              p;
  logic              p_ref;
  logic              accept;
  logic              word_err;
  mode_e             mode;
  par_sel_e          sel;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_par_q, out_par_d;
  logic              out_err_q, out_err_d;
  logic              err_sticky_q, err_sticky_d;

  parity_tree #(.DATA_W(DATA_W)) u_tree (
    .data_i (in_data),
    .par_o  (p)
  );

  assign mode   = mode_e'(chk_mode);
  assign sel    = par_sel_e'(odd_sel);

  // The parity bit the word should carry under the selected sense; a check-mode
  // error is simply a received bit that differs from it.
  assign p_ref    = p ^ (sel == PAR_ODD);
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign word_err = accept && (mode == MODE_CHK) && (in_par != p_ref);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would infer a latch.
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_par_d    = out_par_q;
    out_err_d    = out_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_par_d   = (mode == MODE_CHK) ? in_par : p_ref;
      out_err_d   = word_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // Set has priority over clear so an error in the clearing cycle is kept.
    if (word_err) begin
      err_sticky_d = 1'b1;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
    end else begin
      err_sticky_d = err_sticky_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_par_q    <= 1'b0;
      out_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_par_q    <= out_par_d;
      out_err_q    <= out_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_par    = out_par_q;
  assign out_err    = out_err_q;
  assign err_sticky = err_sticky_q;

`ifdef PARITY_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = CNT_W'(word_err);
    end else if (word_err && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_stream_chk.sv
// Directed bench for parity_stream_chk: an 8-bit instance (CNT_W=2) and a 4-bit instance.
module tb_parity_stream_chk;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       odd_sel, chk_mode, in_valid, in_ready, in_par;
  logic       out_valid, out_ready, out_par, out_err, err_clr, err_sticky;
  logic [7:0] in_data, out_data;
  logic [1:0] err_cnt;

  logic       odd_sel4, chk_mode4, in_valid4, in_ready4, in_par4;
  logic       out_valid4, out_ready4, out_par4, out_err4, err_clr4, err_sticky4;
  logic [3:0] in_data4, out_data4;
  logic [7:0] err_cnt4;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  parity_stream_chk #(.DATA_W(8), .CNT_W(2)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .odd_sel    (odd_sel),
    .chk_mode   (chk_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_par     (in_par),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_par    (out_par),
    .out_err    (out_err),
    .err_clr    (err_clr),
    .err_sticky (err_sticky)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  parity_stream_chk #(.DATA_W(4), .CNT_W(8)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .odd_sel    (odd_sel4),
    .chk_mode   (chk_mode4),
    .in_valid   (in_valid4),
    .in_ready   (in_ready4),
    .in_data    (in_data4),
    .in_par     (in_par4),
    .out_valid  (out_valid4),
    .out_ready  (out_ready4),
    .out_data   (out_data4),
    .out_par    (out_par4),
    .out_err    (out_err4),
    .err_clr    (err_clr4),
    .err_sticky (err_sticky4)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic par, input logic odd, input logic mode);
    in_data  = d;
    in_par   = par;
    odd_sel  = odd;
    chk_mode = mode;
    in_valid = 1'b1;
  endtask

  // One isolated word: result valid exactly one cycle after acceptance, then gone.
  task automatic send1(input string tag, input logic [7:0] d, input logic par, input logic odd,
                       input logic mode, input logic exp_par, input logic exp_err);
    check({tag, "_idle"}, out_valid, 1'b0);
    drive(d, par, odd, mode);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_par"}, out_par, exp_par);
    check({tag, "_err"}, out_err, exp_err);
    @(negedge clk);
    check({tag, "_drain"}, out_valid, 1'b0);
  endtask

  function automatic logic ref_err4(input logic [3:0] d, input logic par, input logic odd);
    int ones = int'(par);
    for (int i = 0; i < 4; i++) ones += int'(d[i]);
    if (odd) return (ones % 2) == 0;
    else     return (ones % 2) == 1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0] vv;
    int         n_err4;
    logic       e;

    rst_n = 1'b0;
    odd_sel = 1'b0; chk_mode = 1'b0; in_valid = 1'b0; in_data = '0; in_par = 1'b0;
    out_ready = 1'b1; err_clr = 1'b0;
    odd_sel4 = 1'b0; chk_mode4 = 1'b1; in_valid4 = 1'b0; in_data4 = '0; in_par4 = 1'b0;
    out_ready4 = 1'b1; err_clr4 = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_par", out_par, 1'b0);
    check("rst_err", out_err, 1'b0);
    check("rst_sticky", err_sticky, 1'b0);
`ifdef PARITY_ERR_CNT_EN
    check("rst_cnt", err_cnt, 2'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", in_ready, 1'b1);

    // Generate mode
    send1("gen_a5_even", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send1("gen_07_even", 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send1("gen_07_odd",  8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send1("gen_00_odd",  8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("gen_sticky", err_sticky, 1'b0);

    // Check mode
    send1("chk_0f_bad", 8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("chk_bad_sticky", err_sticky, 1'b1);
`ifdef PARITY_ERR_CNT_EN
    check("chk_bad_cnt", err_cnt, 2'd1);
`endif
    send1("chk_0f_ok",  8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send1("chk_0f_odd", 8'h0F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("chk_ok_sticky", err_sticky, 1'b1);
`ifdef PARITY_ERR_CNT_EN
    check("chk_ok_cnt", err_cnt, 2'd1);
`endif
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_sticky", err_sticky, 1'b0);
`ifdef PARITY_ERR_CNT_EN
    check("clr_cnt", err_cnt, 2'd0);
`endif

    // Backpressure: first word stalls, second waits at the input
    out_ready = 1'b0;
    drive(8'h13, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(8'h22, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", in_ready, 1'b0);
      check("bp_valid", out_valid, 1'b1);
      check("bp_data", out_data, 8'h13);
      check("bp_par", out_par, 1'b1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1'b1);
    check("bp_release_data", out_data, 8'h13);
    @(negedge clk);
    check("bp_w1_data", out_data, 8'h22);
    check("bp_w1_par", out_par, 1'b0);
    drive(8'h37, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_w2_valid", out_valid, 1'b1);
    check("bp_w2_data", out_data, 8'h37);
    check("bp_w2_par", out_par, 1'b1);
    @(negedge clk);
    check("bp_drain", out_valid, 1'b0);

    // Saturation and clear/set collision
    drive(8'h0F, 1'b1, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    check("sat_sticky", err_sticky, 1'b1);
`ifdef PARITY_ERR_CNT_EN
    check("sat_cnt", err_cnt, 2'd3);
`endif
    err_clr = 1'b1;
    drive(8'h0F, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    err_clr = 1'b0;
    in_valid = 1'b0;
    check("clr_err_sticky", err_sticky, 1'b1);
`ifdef PARITY_ERR_CNT_EN
    check("clr_err_cnt", err_cnt, 2'd1);
`endif
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr2_sticky", err_sticky, 1'b0);
`ifdef PARITY_ERR_CNT_EN
    check("clr2_cnt", err_cnt, 2'd0);
`endif

    // Reset while a word is held under backpressure
    out_ready = 1'b0;
    drive(8'h0F, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_pre_valid", out_valid, 1'b1);
    check("mid_pre_err", out_err, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 8'h00);
    check("mid_rst_par", out_par, 1'b0);
    check("mid_rst_err", out_err, 1'b0);
    check("mid_rst_sticky", err_sticky, 1'b0);
`ifdef PARITY_ERR_CNT_EN
    check("mid_rst_cnt", err_cnt, 2'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_no_emit", out_valid, 1'b0);
      check("mid_ready", in_ready, 1'b1);
    end

    // Exhaustive 4-bit check mode, both parity senses, back-to-back
    n_err4 = 0;
    for (int odd = 0; odd < 2; odd++) begin
      for (int v = 0; v < 32; v++) begin
        vv = v[4:0];
        in_data4  = vv[4:1];
        in_par4   = vv[0];
        odd_sel4  = odd[0];
        in_valid4 = 1'b1;
        e = ref_err4(vv[4:1], vv[0], odd[0]);
        if (e) n_err4++;
        @(negedge clk);
        check($sformatf("ex_err_o%0d_v%0d", odd, v), out_err4, e);
        check($sformatf("ex_par_o%0d_v%0d", odd, v), out_par4, vv[0]);
        check($sformatf("ex_data_o%0d_v%0d", odd, v), out_data4, vv[4:1]);
      end
    end
    in_valid4 = 1'b0;
    @(negedge clk);
    check("ex_drain", out_valid4, 1'b0);
    check("ex_ready", in_ready4, 1'b1);
    check("ex_sticky", err_sticky4, 1'b1);
`ifdef PARITY_ERR_CNT_EN
    check("ex_cnt", err_cnt4, 32'(n_err4));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
